// File: rtl/cpu_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_trace_pkg
// Description : Shared types for the CPU trace buffer: the trace FSM state
//               encoding and the packed record captured per retired
//               instruction.
//               Optional feature macro: CPU_TRACE_TS_EN adds a timestamp
//               field to every record.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_trace_pkg;

  // Record field widths. The top-level DATA_W / TS_W parameters default to
  // these values and must stay equal to them, since the record struct is
  // sized here.
  localparam int C_DATA_W = 32;
  localparam int C_TS_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    POST = 2'd2,
    HALT = 2'd3
  } trace_state_t;

  typedef struct packed {
    logic [C_DATA_W-1:0] pc;
    logic [C_DATA_W-1:0] rs_value;
    logic [C_DATA_W-1:0] rt_value;
    logic [C_DATA_W-1:0] rd_value;
`ifdef CPU_TRACE_TS_EN
    logic [C_TS_W-1:0]   ts;
`endif
  } trace_rec_t;

endpackage : cpu_trace_pkg
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trace_fifo
// Description : Generic show-ahead FIFO of trace records. The head entry is
//               presented combinationally whenever the FIFO is not empty and
//               reads as all zeros when empty.
// Ports       : clk, rst_n     - clock, async active-low reset
//               push/push_data - write request (ignored when full unless a
//                                pop happens in the same cycle)
//               pop            - remove head (ignored when empty)
//               flush          - empty the FIFO; same-cycle push/pop ignored
//               head           - show-ahead head record
//               full, empty    - status flags
//               level          - occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo
  import cpu_trace_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type T     = trace_rec_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output T                         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int c_aw = $clog2(DEPTH);

  // Counters carry one extra bit above the address so that a full buffer
  // and an empty one are distinguishable; the low bits address the array
  // and wrap naturally.
  logic [c_aw:0] r_wr_cnt;
  logic [c_aw:0] r_rd_cnt;
  T              r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign level     = r_wr_cnt - r_rd_cnt;
  assign empty     = (level == '0);
  assign full      = (level == (c_aw+1)'(DEPTH));
  assign w_do_pop  = pop & ~empty & ~flush;
  assign w_do_push = push & (~full | w_do_pop) & ~flush;
  assign head      = empty ? '0 : r_mem[r_rd_cnt[c_aw-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else if (flush) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_do_push) r_wr_cnt <= r_wr_cnt + (c_aw+1)'(1);
      if (w_do_pop)  r_rd_cnt <= r_rd_cnt + (c_aw+1)'(1);
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_cnt[c_aw-1:0]] <= push_data;
  end

endmodule : trace_fifo
`default_nettype wire

// File: rtl/cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_trace_buffer
// Description : Captures one record per retired instruction into a DEPTH
//               entry buffer under arm / pc-trigger / freeze control and
//               lets a monitor drain it over a valid/ready handshake.
//               Optional feature macro: CPU_TRACE_TS_EN - adds a free-running
//               cycle stamp to each record and the trc_ts output port.
// Ports       : arm                 - pulse: (re)start RUN, flush, clear drops
//               trig_en, trig_pc    - pc trigger in RUN
//               ret_*               - retire-stage record input
//               trc_valid/trc_ready - drain handshake, trc_* head fields
//               trc_level           - buffer occupancy
//               drop_cnt            - saturating count of records lost to full
//               state               - trace FSM state (trace_state_t)
//               trc_ts              - head stamp (CPU_TRACE_TS_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int DATA_W    = C_DATA_W,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  parameter int CNT_W     = 16,
  parameter int TS_W      = C_TS_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm,
  input  logic                     trig_en,
  input  logic [DATA_W-1:0]        trig_pc,
  input  logic                     ret_valid,
  input  logic [DATA_W-1:0]        ret_pc,
  input  logic [DATA_W-1:0]        ret_rs_value,
  input  logic [DATA_W-1:0]        ret_rt_value,
  input  logic [DATA_W-1:0]        ret_rd_value,
  output logic                     trc_valid,
  input  logic                     trc_ready,
  output logic [DATA_W-1:0]        trc_pc,
  output logic [DATA_W-1:0]        trc_rs_value,
  output logic [DATA_W-1:0]        trc_rt_value,
  output logic [DATA_W-1:0]        trc_rd_value,
  output logic [$clog2(DEPTH):0]   trc_level,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [1:0]               state
`ifdef CPU_TRACE_TS_EN
  ,
  output logic [TS_W-1:0]          trc_ts
`endif
);

  localparam int c_pw = $clog2(DEPTH);

  trace_state_t      r_state;
  logic [c_pw-1:0]   r_post_cnt;
  logic [CNT_W-1:0]  r_drop_cnt;

  trace_rec_t        w_rec;
  trace_rec_t        w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_capture;
  logic              w_pop;
  logic              w_accept;
  logic              w_drop;
  logic              w_trig;

  // A full buffer still takes a record when the monitor frees a slot in the
  // same cycle. Arm flushes, so captures and pops in that cycle are void.
  assign w_capture = ret_valid & ((r_state == RUN) | (r_state == POST)) & ~arm;
  assign w_pop     = ~w_empty & trc_ready & ~arm;
  assign w_accept  = w_capture & (~w_full | w_pop);
  assign w_drop    = w_capture & ~w_accept;
  assign w_trig    = ret_valid & trig_en & (ret_pc == trig_pc);

  assign w_rec.pc       = ret_pc;
  assign w_rec.rs_value = ret_rs_value;
  assign w_rec.rt_value = ret_rt_value;
  assign w_rec.rd_value = ret_rd_value;

`ifdef CPU_TRACE_TS_EN
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ts <= '0;
    else        r_ts <= r_ts + TS_W'(1);
  end

  assign w_rec.ts = r_ts;
  assign trc_ts   = w_head.ts;
`endif

  trace_fifo #(
    .DEPTH (DEPTH),
    .T     (trace_rec_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_accept),
    .push_data (w_rec),
    .pop       (w_pop),
    .flush     (arm),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .level     (trc_level)
  );

  // Trace control FSM with the post-trigger countdown and drop counter.
  // The trigger record itself is captured in RUN; POST then counts every
  // further retire (accepted or dropped) down to HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_post_cnt <= '0;
      r_drop_cnt <= '0;
    end else if (arm) begin
      r_state    <= RUN;
      r_post_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_drop && (r_drop_cnt != {CNT_W{1'b1}}))
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      case (r_state)
        RUN: begin
          if (w_trig) begin
            if (POST_TRIG == 0) begin
              r_state <= HALT;
            end else begin
              r_state    <= POST;
              r_post_cnt <= c_pw'(POST_TRIG);
            end
          end
        end
        POST: begin
          if (ret_valid) begin
            r_post_cnt <= r_post_cnt - c_pw'(1);
            if (r_post_cnt <= c_pw'(1)) r_state <= HALT;
          end
        end
        default: ;
      endcase
    end
  end

  assign state        = r_state;
  assign drop_cnt     = r_drop_cnt;
  assign trc_valid    = ~w_empty;
  assign trc_pc       = w_head.pc;
  assign trc_rs_value = w_head.rs_value;
  assign trc_rt_value = w_head.rt_value;
  assign trc_rd_value = w_head.rd_value;

endmodule : cpu_trace_buffer
`default_nettype wire
